write_mem_control: RTL and testbench
====================================

WRITE_MEM_CONTROL -- requirements
Module: write_mem_control

Interface
REQ-001 Parameter DEPTH, default 4, store-buffer entry count; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 st_valid  input  1  store request from pipeline.
REQ-005 st_ready  output  1  buffer can accept a store this cycle.
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_data  input  32  unshifted register data; the store uses its low byte, low half, or full word.
REQ-008 st_size  input  2  store size: 00 SB, 01 SH, 10 SW, 11 illegal.
REQ-009 st_err  output  1  one-cycle pulse flagging a dropped store.
REQ-010 ld_addr  input  32  byte address of an in-flight load, for hazard check.
REQ-011 ld_hazard  output  1  a buffered store targets ld_addr's word.
REQ-012 mem_we  output  1  write request to data memory.
REQ-013 mem_ready  input  1  memory accepts the current write.
REQ-014 mem_addr  output  30  word address (byte address bits 31:2).
REQ-015 mem_din  output  32  lane-aligned write data.
REQ-016 mem_be  output  4  byte enables; bit n enables data bits 8n+7:8n.

Function
REQ-017 A store is accepted when st_valid and st_ready are both high on a clock edge.
REQ-018 st_ready equals not-full; there is no same-cycle bypass when full, even if an entry pops that cycle.
REQ-019 Only addresses with addr[31]==0 and addr[28]==1 are data-memory stores; other accepted stores are discarded silently, with no entry and no st_err.
REQ-020 SB: mem_din = st_data[7:0] replicated to four lanes; mem_be = 0001 shifted left by addr[1:0].
REQ-021 SH: mem_din = {st_data[15:0], st_data[15:0]}; mem_be = 1100 if addr[1] else 0011.
REQ-022 SW: mem_din = st_data; mem_be = 1111.
REQ-023 st_size 11: the store is dropped and st_err pulses the cycle after acceptance.
REQ-024 The buffer is an in-order FIFO of {word address, be, data}; a pushed entry is visible on the mem_* ports on the next cycle at the earliest.
REQ-025 mem_we is high whenever the buffer is non-empty; mem_addr, mem_din and mem_be show the head entry and stay stable until it is popped.
REQ-026 The head entry pops on a clock edge where mem_we and mem_ready are both high.
REQ-027 When the buffer is not full, a simultaneous push and pop leaves the occupancy unchanged.
REQ-028 Read and write pointers wrap modulo DEPTH.
REQ-029 ld_hazard is combinational: it is high if any valid entry's word address equals ld_addr[31:2], including an entry popping that cycle.
REQ-030 When empty, mem_we = 0, and mem_addr, mem_din and mem_be are all-zero.

Reset
REQ-031 While rst is high: the buffer empties, pointers clear, st_ready = 0, and mem_we, mem_be, mem_addr, mem_din, st_err and ld_hazard are all 0.
REQ-032 Reset mid-operation discards all pending entries without issuing them; st_ready returns to 1 in the first cycle after rst falls.

Configuration
REQ-033 Macro WRITE_MISALIGN_TRAP_EN: when defined, an SH with addr[0]=1, or an SW with addr[1:0]!=00, is dropped and pulses st_err.
REQ-034 Without WRITE_MISALIGN_TRAP_EN, misaligned stores are force-aligned: SH ignores addr[0] and SW ignores addr[1:0]. The store is written and st_err stays low.

Verification
REQ-035 SB, addr 0x10000003, data 0x000000A5, mem_ready=1 -> next cycle: mem_we=1, mem_addr=0x04000000, mem_be=1000, mem_din=0xA5A5A5A5; popped on that edge.
REQ-036 mem_ready=0, DEPTH=4, five SW stores -> st_ready=0 after the fourth; raising mem_ready drains the four stores in order; the fifth is accepted only once the buffer is not full.
REQ-037 SH at 0x10000001: with WRITE_MISALIGN_TRAP_EN -> st_err pulses, no write; without it -> mem_be=0011, write issued.
REQ-038 Store to 0x80000000 -> no entry, mem_we stays 0, st_err=0; size 11 to 0x10000000 -> st_err pulses once.
REQ-039 Buffer holds a store to 0x10000008 -> ld_addr=0x1000000A gives ld_hazard=1; ld_addr=0x1000000C gives ld_hazard=0.
REQ-040 Assert rst with three entries pending -> mem_we=0 immediately; after release, no stale writes are issued and st_ready=1.

Source files
------------

// File: rtl/write_mem_control.sv
// ----------------------------------------------------------------------------
// write_mem_control
//
// Store buffer between the pipeline and the data memory. Each accepted store
// is decoded into a word address, lane-aligned write data and byte enables.
// Stores to the data-memory region are queued in an in-order FIFO and issued
// to memory one at a time from the head entry.
//
// Handshakes (both follow the same valid/ready rule): a transfer happens on a
// rising clk edge where the valid-side signal and the ready-side signal are
// both high. Valid-side data must be held stable until that edge. Pipeline
// side: st_valid / st_ready. Memory side: mem_we / mem_ready.
//
// Parameters
//   DEPTH      store-buffer entry count, power of two, 2..16
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   st_valid   store request from the pipeline
//   st_ready   buffer can accept a store this cycle (not full, not in reset)
//   st_addr    byte address of the store
//   st_data    unshifted register data
//   st_size    00 SB, 01 SH, 10 SW, 11 illegal
//   st_err     one-cycle pulse, the cycle after a dropped store was accepted
//   ld_addr    byte address of an in-flight load
//   ld_hazard  a buffered store targets the word of ld_addr
//   mem_we     write request (buffer non-empty)
//   mem_ready  memory accepts the current write
//   mem_addr   word address of the head entry
//   mem_din    lane-aligned write data of the head entry
//   mem_be     byte enables of the head entry
//
// Build option
//   WRITE_MISALIGN_TRAP_EN  when defined, misaligned SH/SW stores are dropped
//                           and flagged on st_err; otherwise they are
//                           force-aligned and written.
// ----------------------------------------------------------------------------
module write_mem_control #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_err,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_be
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Buffer storage
    logic [29:0]      addr_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic full;
    logic empty;
    logic accept;
    logic in_region;
    logic size_ok;
    logic drop;
    logic push;
    logic pop;
    logic err_next;

    logic [3:0]  fmt_be;
    logic [31:0] fmt_data;

    // Low address bits of the load only select a byte within the word.
    logic unused_ld_bits;
    assign unused_ld_bits = ^ld_addr[1:0];

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    // No bypass: a pop in the same cycle does not open a slot early.
    assign st_ready = ~rst & ~full;
    assign accept   = st_valid & st_ready;

    // Data-memory window: bit 31 clear and bit 28 set.
    assign in_region = ~st_addr[31] & st_addr[28];

    // Lane formatting. Word address always drops addr[1:0], which is what
    // force-aligns misaligned SH/SW when trapping is disabled.
    always_comb begin
        fmt_be   = 4'b0000;
        fmt_data = 32'h0;
        size_ok  = 1'b0;
        case (st_size)
            2'b00: begin
                fmt_be   = 4'b0001 << st_addr[1:0];
                fmt_data = {4{st_data[7:0]}};
                size_ok  = 1'b1;
            end
            2'b01: begin
                fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{st_data[15:0]}};
                size_ok  = 1'b1;
            end
            2'b10: begin
                fmt_be   = 4'b1111;
                fmt_data = st_data;
                size_ok  = 1'b1;
            end
            default: begin
                fmt_be   = 4'b0000;
                fmt_data = 32'h0;
                size_ok  = 1'b0;
            end
        endcase
    end

`ifdef WRITE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((st_size == 2'b01) & st_addr[0]) |
                        ((st_size == 2'b10) & (|st_addr[1:0]));
    assign drop = ~size_ok | misaligned;
`else
    assign drop = ~size_ok;
`endif

    // Out-of-region stores vanish without an error; in-region bad stores
    // are dropped and reported.
    assign push     = accept & in_region & ~drop;
    assign err_next = accept & in_region & drop;
    assign pop      = mem_we & mem_ready;

    // Pointers, occupancy, entry-valid flags and the error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            st_err  <= 1'b0;
        end else begin
            st_err <= err_next;
            // push only when not full and pop only when not empty, so the
            // two updates below never touch the same slot in one cycle.
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_ONE;
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible through valid_q
    // and the empty gating below.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            be_q[wr_ptr]   <= fmt_be;
            data_q[wr_ptr] <= fmt_data;
        end
    end

    assign mem_we   = ~empty;
    assign mem_addr = empty ? 30'h0 : addr_q[rd_ptr];
    assign mem_din  = empty ? 32'h0 : data_q[rd_ptr];
    assign mem_be   = empty ? 4'h0  : be_q[rd_ptr];

    // Includes the head entry even on the cycle it pops.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_write_mem_control.sv
// ----------------------------------------------------------------------------
// tb_write_mem_control
//
// Directed bench for write_mem_control (DEPTH = 4). Every accepted store is
// run through a reference model; stores that should reach memory push their
// expected {word address, be, data} onto exp_q, and a monitor pops and
// compares on every memory write handshake.
// ----------------------------------------------------------------------------
module tb_write_mem_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_we;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_be;

    int vectors     = 0;
    int miscompares = 0;
    logic [65:0] exp_q[$];
    logic        last_err;

    write_mem_control #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_err    (st_err),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_be    (mem_be)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] sz, output logic wr,
                                  output logic err, output logic [65:0] ent);
        logic [3:0]  be;
        logic [31:0] din;
        logic        bad;
        wr  = 1'b0;
        err = 1'b0;
        ent = '0;
        be  = 4'b0000;
        din = 32'h0;
        bad = 1'b0;
        if (!(a[31] == 1'b0 && a[28] == 1'b1)) return;
        case (sz)
            2'd0: begin
                case (a[1:0])
                    2'd0: be = 4'b0001;
                    2'd1: be = 4'b0010;
                    2'd2: be = 4'b0100;
                    default: be = 4'b1000;
                endcase
                din = {d[7:0], d[7:0], d[7:0], d[7:0]};
            end
            2'd1: begin
                be  = a[1] ? 4'b1100 : 4'b0011;
                din = {d[15:0], d[15:0]};
`ifdef WRITE_MISALIGN_TRAP_EN
                bad = a[0];
`endif
            end
            2'd2: begin
                be  = 4'b1111;
                din = d;
`ifdef WRITE_MISALIGN_TRAP_EN
                bad = (a[1:0] != 2'b00);
`endif
            end
            default: bad = 1'b1;
        endcase
        err = bad;
        wr  = !bad;
        ent = {a[31:2], be, din};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a posedge; returns just after the accepting posedge.
    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, output int waits);
        logic        wr;
        logic        err;
        logic [65:0] ent;
        logic        ok;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        waits    = 0;
        ok       = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = st_ready;
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        st_valid = 1'b0;
        if (!ok) begin
            check("store_accept_timeout", {65'b0, ok}, 66'd1);
            last_err = 1'b0;
        end else begin
            model(a, d, sz, wr, err, ent);
            last_err = err;
            if (wr) exp_q.push_back(ent);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mem_we) break;
        end
        check("drain", {65'b0, mem_we}, 66'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_write", {65'b0, mem_we}, 66'd0);
            else
                check("write_entry", {mem_addr, mem_be, mem_din}, exp_q.pop_front());
        end
    end

    // ---------------- directed steps ----------------
    initial begin
        int          w;
        logic [31:0] ra;
        logic [1:0]  rs;

        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_size   = '0;
        ld_addr   = 32'h10000000;
        mem_ready = 1'b0;
        last_err  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_st_ready",  {65'b0, st_ready},  66'd0);
        check("rst_mem_we",    {65'b0, mem_we},    66'd0);
        check("rst_mem_outs",  {mem_addr, mem_be, mem_din}, 66'd0);
        check("rst_st_err",    {65'b0, st_err},    66'd0);
        check("rst_ld_hazard", {65'b0, ld_hazard}, 66'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_st_ready", {65'b0, st_ready}, 66'd1);
        @(posedge clk);
        #1;

        // SB to the top lane, popped on its first visible cycle
        mem_ready = 1'b1;
        store(32'h10000003, 32'h000000A5, 2'd0, w);
        @(negedge clk);
        check("sb_mem_we",   {65'b0, mem_we}, 66'd1);
        check("sb_mem_addr", {36'b0, mem_addr}, 66'h04000000);
        check("sb_mem_be",   {62'b0, mem_be}, 66'b1000);
        check("sb_mem_din",  {34'b0, mem_din}, 66'hA5A5A5A5);
        @(negedge clk);
        check("sb_popped", {65'b0, mem_we}, 66'd0);
        @(posedge clk);
        #1;

        // Fill with memory stalled, then drain; fifth waits for a free slot
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            store(32'h10000010 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'd2, w);
        @(negedge clk);
        check("full_st_ready", {65'b0, st_ready}, 66'd0);
        check("full_head_addr", {36'b0, mem_addr}, 66'h04000004);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        store(32'h10000020, 32'hC0DE0004, 2'd2, w);
        check("no_bypass_waits", 66'(w), 66'd1);
        wait_drain();
        @(posedge clk);
        #1;

        // Randomised mix of sizes and lanes, with memory stalls
        for (int i = 0; i < 12; i++) begin
            mem_ready = (i % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            ra = 32'h10000100 + 32'($urandom_range(0, 255));
            rs = 2'($urandom_range(0, 2));
            store(ra, $urandom, rs, w);
            @(negedge clk);
            check("rand_st_err", {65'b0, st_err}, {65'b0, last_err});
            if (mem_ready) wait_drain();
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;

        // Misaligned SH
        store(32'h10000001, 32'h1234BEEF, 2'd1, w);
        @(negedge clk);
`ifdef WRITE_MISALIGN_TRAP_EN
        check("mis_sh_err", {65'b0, st_err}, 66'd1);
        check("mis_sh_no_write", {65'b0, mem_we}, 66'd0);
`else
        check("mis_sh_err", {65'b0, st_err}, 66'd0);
        check("mis_sh_be", {62'b0, mem_be}, 66'b0011);
`endif
        @(negedge clk);
        check("mis_sh_err_off", {65'b0, st_err}, 66'd0);
        wait_drain();
        @(posedge clk);
        #1;

        // Misaligned SW
        store(32'h10000006, 32'hFEEDF00D, 2'd2, w);
        @(negedge clk);
        check("mis_sw_err", {65'b0, st_err}, {65'b0, last_err});
        wait_drain();
        @(posedge clk);
        #1;

        // Out-of-region stores vanish silently
        store(32'h80000000, 32'h11111111, 2'd2, w);
        @(negedge clk);
        check("oor_hi_err", {65'b0, st_err}, 66'd0);
        check("oor_hi_we",  {65'b0, mem_we}, 66'd0);
        @(posedge clk);
        #1;
        store(32'h00000040, 32'h22222222, 2'd0, w);
        @(negedge clk);
        check("oor_lo_err", {65'b0, st_err}, 66'd0);
        check("oor_lo_we",  {65'b0, mem_we}, 66'd0);
        @(posedge clk);
        #1;

        // Illegal size
        store(32'h10000000, 32'h33333333, 2'd3, w);
        @(negedge clk);
        check("ill_err", {65'b0, st_err}, 66'd1);
        check("ill_we",  {65'b0, mem_we}, 66'd0);
        @(negedge clk);
        check("ill_err_once", {65'b0, st_err}, 66'd0);
        @(posedge clk);
        #1;

        // Load hazard against a held store
        mem_ready = 1'b0;
        store(32'h10000008, 32'h44444444, 2'd2, w);
        ld_addr = 32'h1000000A;
        #1 check("hazard_same_word", {65'b0, ld_hazard}, 66'd1);
        ld_addr = 32'h1000000C;
        #1 check("hazard_next_word", {65'b0, ld_hazard}, 66'd0);
        mem_ready = 1'b1;
        wait_drain();
        @(posedge clk);
        #1;

        // Reset with three entries pending
        mem_ready = 1'b0;
        store(32'h10000100, 32'h55555555, 2'd2, w);
        store(32'h10000104, 32'h66666666, 2'd2, w);
        store(32'h10000108, 32'h77777777, 2'd2, w);
        ld_addr = 32'h10000104;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_mem_we",    {65'b0, mem_we},    66'd0);
        check("mid_rst_st_ready",  {65'b0, st_ready},  66'd0);
        check("mid_rst_ld_hazard", {65'b0, ld_hazard}, 66'd0);
        check("mid_rst_mem_outs",  {mem_addr, mem_be, mem_din}, 66'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("after_rst_st_ready", {65'b0, st_ready}, 66'd1);
        for (int i = 0; i < 4; i++) begin
            check("after_rst_no_write", {65'b0, mem_we}, 66'd0);
            @(negedge clk);
        end

        check("exp_q_empty", 66'(exp_q.size()), 66'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
